// File: rtl/cpu_pkg.sv
// Shared constants and encodings for the DPCPU pipeline control logic.
package cpu_pkg;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam int MD_LAT_DEF = 4;
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/md_busy_timer.sv
// MUL/DIV occupancy tracker: goes busy on a start strobe for MD_LAT cycles.
module md_busy_timer
  import cpu_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEF
) (
  input  logic Clk,
  input  logic Clrn,
  input  logic Md_Start,
  output logic Md_Busy
);

  localparam int CW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MD_LAT - 1);

  md_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MD_IDLE: begin
        if (Md_Start) begin
          state_d = MD_BUSY;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = MD_IDLE;
        end
      end
      MD_BUSY: begin
        if (cnt_q != {CW{1'b0}}) begin
          cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        end else begin
          state_d = MD_IDLE;
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Clrn) begin
      state_q <= MD_IDLE;
      cnt_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Md_Busy = (state_q == MD_BUSY);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: merges RAW, MUL/DIV occupancy and branch redirects into
// PC/IF/ID/ID/EX controls, and counts stall cycles.
module pipe_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEF,
  parameter int CNT_W  = 16
) (
  input  logic             Clk,
  input  logic             Clrn,
  input  logic [4:0]       Rs,
  input  logic [4:0]       Rt,
  input  logic             Regrt,
  input  logic             E_Wreg,
  input  logic [4:0]       E_Rn,
  input  logic             M_Wreg,
  input  logic [4:0]       M_Rn,
  input  logic             D_Md,
  input  logic             D_Hilo,
  input  logic             E_Br_Taken,
  output logic             Pc_We,
  output logic             Ifid_We,
  output logic             Ifid_Flush,
  output logic             Idex_Bubble,
  output logic             Md_Start,
  output logic             Md_Busy,
  output logic             Stall,
  output logic [CNT_W-1:0] Stall_Cnt
);

  logic raw_e, raw_m, md_haz, stall_s;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Rt is only a source when the instruction does not write it.
  assign raw_e = E_Wreg & (E_Rn != REG_ZERO) &
                 ((Rs == E_Rn) | (~Regrt & (Rt == E_Rn)));
  assign raw_m = M_Wreg & (M_Rn != REG_ZERO) &
                 ((Rs == M_Rn) | (~Regrt & (Rt == M_Rn)));
  assign md_haz  = Md_Busy & (D_Md | D_Hilo);
  assign stall_s = ~E_Br_Taken & (raw_e | raw_m | md_haz);

  always_comb begin
    Pc_We       = 1'b1;
    Ifid_We     = 1'b1;
    Ifid_Flush  = 1'b0;
    Idex_Bubble = 1'b0;
    Md_Start    = 1'b0;
    if (!Clrn) begin
      Pc_We       = 1'b0;
      Ifid_We     = 1'b0;
      Ifid_Flush  = 1'b1;
      Idex_Bubble = 1'b1;
    end else if (E_Br_Taken) begin
      Ifid_Flush  = 1'b1;
      Idex_Bubble = 1'b1;
    end else if (stall_s) begin
      Pc_We       = 1'b0;
      Ifid_We     = 1'b0;
      Idex_Bubble = 1'b1;
    end else begin
      Md_Start = D_Md;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Clrn) begin
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  md_busy_timer #(.MD_LAT(MD_LAT)) u_md_timer (
    .Clk      (Clk),
    .Clrn     (Clrn),
    .Md_Start (Md_Start),
    .Md_Busy  (Md_Busy)
  );

  assign Stall     = stall_s;
  assign Stall_Cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a negedge
// monitor pops and compares against the DUT outputs.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 4;

  logic clk;
  logic Clrn;
  logic [4:0] Rs, Rt, E_Rn, M_Rn;
  logic Regrt, E_Wreg, M_Wreg, D_Md, D_Hilo, E_Br_Taken;
  logic Pc_We, Ifid_We, Ifid_Flush, Idex_Bubble, Md_Start, Md_Busy, Stall;
  logic [CNT_W-1:0] Stall_Cnt;

  typedef struct packed {
    logic pc, ifid, flush, bub, start, busy, stall;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;

  pipe_hazard_ctrl #(.MD_LAT(4), .CNT_W(CNT_W)) dut (
    .Clk(clk), .Clrn(Clrn), .Rs(Rs), .Rt(Rt), .Regrt(Regrt),
    .E_Wreg(E_Wreg), .E_Rn(E_Rn), .M_Wreg(M_Wreg), .M_Rn(M_Rn),
    .D_Md(D_Md), .D_Hilo(D_Hilo), .E_Br_Taken(E_Br_Taken),
    .Pc_We(Pc_We), .Ifid_We(Ifid_We), .Ifid_Flush(Ifid_Flush),
    .Idex_Bubble(Idex_Bubble), .Md_Start(Md_Start), .Md_Busy(Md_Busy),
    .Stall(Stall), .Stall_Cnt(Stall_Cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: outputs are valid mid-cycle, one expectation per presented cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp("Pc_We",       {3'b000, Pc_We},       {3'b000, e.pc});
      cmp("Ifid_We",     {3'b000, Ifid_We},     {3'b000, e.ifid});
      cmp("Ifid_Flush",  {3'b000, Ifid_Flush},  {3'b000, e.flush});
      cmp("Idex_Bubble", {3'b000, Idex_Bubble}, {3'b000, e.bub});
      cmp("Md_Start",    {3'b000, Md_Start},    {3'b000, e.start});
      cmp("Md_Busy",     {3'b000, Md_Busy},     {3'b000, e.busy});
      cmp("Stall",       {3'b000, Stall},       {3'b000, e.stall});
      cmp("Stall_Cnt",   Stall_Cnt,             e.cnt);
    end
  end

  task automatic idle_in();
    Rs = 5'd0; Rt = 5'd0; Regrt = 1'b0;
    E_Wreg = 1'b0; E_Rn = 5'd0; M_Wreg = 1'b0; M_Rn = 5'd0;
    D_Md = 1'b0; D_Hilo = 1'b0; E_Br_Taken = 1'b0;
  endtask

  // Push the expectation for the current cycle, then advance one cycle.
  task automatic chk(input logic pc, input logic ifid, input logic flush, input logic bub,
                     input logic start, input logic busy, input logic stall,
                     input logic [CNT_W-1:0] cnt);
    exp_t e;
    e = '{pc: pc, ifid: ifid, flush: flush, bub: bub, start: start,
          busy: busy, stall: stall, cnt: cnt};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  localparam logic R = 1'b1;  // readability aid for run/stall columns

  initial begin
    Clrn = 1'b0;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    // In reset: forced controls
    chk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    Clrn = 1'b1;
    chk(R, R, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

    // Load-use against EX
    E_Wreg = 1'b1; E_Rn = 5'd5; Rs = 5'd5;
    chk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    idle_in();
    chk(R, R, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);

    // Rt with Regrt set is not a source
    E_Wreg = 1'b1; E_Rn = 5'd7; Rt = 5'd7; Rs = 5'd3; Regrt = 1'b1;
    chk(R, R, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
    Regrt = 1'b0;
    chk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1);
    // Register zero never hazards
    E_Rn = 5'd0; Rs = 5'd0; Rt = 5'd0;
    chk(R, R, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
    // MEM producer through Rt
    idle_in();
    M_Wreg = 1'b1; M_Rn = 5'd9; Rt = 5'd9;
    chk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2);

    // MD sequencing
    idle_in();
    D_Md = 1'b1;
    chk(R, R, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3);
    D_Md = 1'b0; D_Hilo = 1'b1;
    chk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd3);
    chk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd4);
    chk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd5);
    D_Hilo = 1'b0; D_Md = 1'b1;  // final busy cycle: new MD still stalled
    chk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd6);
    chk(R, R, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd7);

    // Branch over stall, and branch does not abort the in-flight MD
    idle_in();
    E_Br_Taken = 1'b1; M_Wreg = 1'b1; M_Rn = 5'd9; Rs = 5'd9; D_Md = 1'b1;
    chk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd7);
    idle_in();
    chk(R, R, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd7);
    D_Hilo = 1'b1;
    chk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd7);
    D_Hilo = 1'b0; D_Md = 1'b1;
    chk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd8);
    idle_in();
    chk(R, R, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd9);

    // Saturation: 20 stall cycles starting from 9
    E_Wreg = 1'b1; E_Rn = 5'd12; Rs = 5'd12;
    for (int i = 0; i < 20; i++) begin
      chk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
          (9 + i > 15) ? 4'hF : 4'(9 + i));
    end
    idle_in();
    chk(R, R, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF);

    // Reset during BUSY
    D_Md = 1'b1;
    chk(R, R, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'hF);
    D_Md = 1'b0;
    chk(R, R, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF);
    Clrn = 1'b0;
    chk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF);
    Clrn = 1'b1;
    chk(R, R, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    chk(R, R, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

    // Drain: the monitor must consume every expectation within a bound
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
